// File: rtl/enc_dec_scoreboard.sv
// Cycle-accurate checking scoreboard for the ECC encoder/decoder: times APB-started operations, compares DUT results to the golden model.
// Optional macro ENC_DEC_SCOREBOARD_HIST_EN enables per-error-count pass histograms and maximum-latency tracking.
module enc_dec_scoreboard #(
    parameter int DATA_WIDTH      = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int MAX_LATENCY     = 8,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [AMBA_WORD-1:0]       PRDATA,
    input  logic [AMBA_WORD-1:0]       regs_expected,
    input  logic [DATA_WIDTH-1:0]      data_out,
    input  logic                       operation_done,
    input  logic [1:0]                 num_of_errors,
    input  logic [DATA_WIDTH-1:0]      gm_data_out,
    input  logic [1:0]                 gm_num_of_errors,
    input  logic                       clr_stats,
    output logic                       busy,
    output logic [CNT_WIDTH-1:0]       pass_count,
    output logic [CNT_WIDTH-1:0]       fail_count,
    output logic [CNT_WIDTH-1:0]       timeout_count,
    output logic [5:0]                 err_flags,
    output logic [CNT_WIDTH-1:0]       last_latency,
    output logic [CNT_WIDTH-1:0]       hist0,
    output logic [CNT_WIDTH-1:0]       hist1,
    output logic [CNT_WIDTH-1:0]       hist2,
    output logic [CNT_WIDTH-1:0]       max_latency_seen
);

    localparam int LAT_W = $clog2(MAX_LATENCY + 2);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        sat_inc = (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    state_t               state_q, state_d;
    logic [LAT_W-1:0]     lat_q, lat_d;
    logic [LAT_W-1:0]     lat_inc_s;
    logic                 busy_q;
    logic [CNT_WIDTH-1:0] pass_q, pass_d;
    logic [CNT_WIDTH-1:0] fail_q, fail_d;
    logic [CNT_WIDTH-1:0] to_q, to_d;
    logic [5:0]           flags_q, flags_d;
    logic [CNT_WIDTH-1:0] last_q, last_d;
    logic                 start_s;
    logic                 done_s;
    logic                 rd_mismatch_s;
    logic                 data_ok_s;
    logic                 cnt_ok_s;
    logic                 illegal_s;
    logic                 pass_s;
`ifdef ENC_DEC_SCOREBOARD_HIST_EN
    logic [CNT_WIDTH-1:0] hist0_q, hist0_d;
    logic [CNT_WIDTH-1:0] hist1_q, hist1_d;
    logic [CNT_WIDTH-1:0] hist2_q, hist2_d;
    logic [CNT_WIDTH-1:0] maxl_q, maxl_d;
`endif

    assign start_s       = PSEL & PENABLE & PWRITE & (PADDR[3:0] == 4'd0);
    assign done_s        = operation_done;
    assign rd_mismatch_s = PSEL & PENABLE & ~PWRITE & (PRDATA != regs_expected);
    // Two-bit errors are uncorrectable, so the data word is not compared then.
    assign data_ok_s     = (num_of_errors == 2'd2) | (data_out == gm_data_out);
    assign cnt_ok_s      = (num_of_errors == gm_num_of_errors);
    assign illegal_s     = (num_of_errors == 2'd3);
    assign pass_s        = data_ok_s & cnt_ok_s & ~illegal_s;
    assign lat_inc_s     = lat_q + LAT_W'(1);

    // Next-state, check and statistics update logic.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        to_d    = to_q;
        flags_d = flags_q;
        last_d  = last_q;
`ifdef ENC_DEC_SCOREBOARD_HIST_EN
        hist0_d = hist0_q;
        hist1_d = hist1_q;
        hist2_d = hist2_q;
        maxl_d  = maxl_q;
`endif
        if (rd_mismatch_s) begin
            flags_d[4] = 1'b1;
        end else begin
            flags_d[4] = flags_q[4];
        end

        case (state_q)
            ST_IDLE: begin
                if (done_s) begin
                    flags_d[5] = 1'b1;
                end else begin
                    flags_d[5] = flags_q[5];
                end
                if (start_s) begin
                    state_d = ST_WAIT;
                    lat_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                lat_d = lat_inc_s;
                if (done_s) begin
                    last_d = CNT_WIDTH'(lat_inc_s);
`ifdef ENC_DEC_SCOREBOARD_HIST_EN
                    if (CNT_WIDTH'(lat_inc_s) > maxl_q) begin
                        maxl_d = CNT_WIDTH'(lat_inc_s);
                    end else begin
                        maxl_d = maxl_q;
                    end
`endif
                    if (pass_s) begin
                        pass_d = sat_inc(pass_q);
`ifdef ENC_DEC_SCOREBOARD_HIST_EN
                        case (num_of_errors)
                            2'd0:    hist0_d = sat_inc(hist0_q);
                            2'd1:    hist1_d = sat_inc(hist1_q);
                            2'd2:    hist2_d = sat_inc(hist2_q);
                            default: hist0_d = hist0_q;
                        endcase
`endif
                    end else begin
                        fail_d     = sat_inc(fail_q);
                        flags_d[0] = flags_q[0] | ~data_ok_s;
                        flags_d[1] = flags_q[1] | ~cnt_ok_s;
                        flags_d[2] = flags_q[2] | illegal_s;
                    end
                    // A new start on the done edge begins the next op immediately.
                    if (start_s) begin
                        state_d = ST_WAIT;
                        lat_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (start_s) begin
                    flags_d[5] = 1'b1;
                    fail_d     = sat_inc(fail_q);
                    lat_d      = '0;
                    state_d    = ST_WAIT;
                end else if (lat_inc_s == LAT_W'(MAX_LATENCY)) begin
                    to_d       = sat_inc(to_q);
                    fail_d     = sat_inc(fail_q);
                    flags_d[3] = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                lat_d   = '0;
            end
        endcase

        if (clr_stats) begin
            pass_d  = '0;
            fail_d  = '0;
            to_d    = '0;
            flags_d = 6'd0;
            last_d  = '0;
`ifdef ENC_DEC_SCOREBOARD_HIST_EN
            hist0_d = '0;
            hist1_d = '0;
            hist2_d = '0;
            maxl_d  = '0;
`endif
        end else begin
            pass_d = pass_d;
        end
    end

    // State, timer and statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lat_q   <= '0;
            busy_q  <= 1'b0;
            pass_q  <= '0;
            fail_q  <= '0;
            to_q    <= '0;
            flags_q <= 6'd0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            busy_q  <= (state_d == ST_WAIT);
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            to_q    <= to_d;
            flags_q <= flags_d;
            last_q  <= last_d;
        end
    end

`ifdef ENC_DEC_SCOREBOARD_HIST_EN
    // Histogram and maximum-latency registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist0_q <= '0;
            hist1_q <= '0;
            hist2_q <= '0;
            maxl_q  <= '0;
        end else begin
            hist0_q <= hist0_d;
            hist1_q <= hist1_d;
            hist2_q <= hist2_d;
            maxl_q  <= maxl_d;
        end
    end

    assign hist0            = hist0_q;
    assign hist1            = hist1_q;
    assign hist2            = hist2_q;
    assign max_latency_seen = maxl_q;
`else
    assign hist0            = '0;
    assign hist1            = '0;
    assign hist2            = '0;
    assign max_latency_seen = '0;
`endif

    assign busy          = busy_q;
    assign pass_count    = pass_q;
    assign fail_count    = fail_q;
    assign timeout_count = to_q;
    assign err_flags     = flags_q;
    assign last_latency  = last_q;

endmodule

// File: tb/tb_enc_dec_scoreboard.sv
// Directed, table-driven self-checking bench for enc_dec_scoreboard.
module tb_enc_dec_scoreboard;

`ifdef ENC_DEC_SCOREBOARD_HIST_EN
    localparam bit HIST = 1'b1;
`else
    localparam bit HIST = 1'b0;
`endif
    localparam int MAXL = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] paddr = 20'd0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] prdata = 32'd0, regs_exp = 32'd0;
    logic [31:0] dout = 32'd0, gm = 32'd0;
    logic        done = 1'b0;
    logic [1:0]  noe = 2'd0, gnoe = 2'd0;
    logic        clr = 1'b0;

    logic        busy;
    logic [15:0] pass_c, fail_c, to_c, last_l, h0, h1, h2, maxl;
    logic [5:0]  flags;
    logic        s_busy;
    logic [1:0]  s_pass, s_fail, s_to, s_last, s_h0, s_h1, s_h2, s_maxl;
    logic [5:0]  s_flags;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    enc_dec_scoreboard #(.MAX_LATENCY(MAXL), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .PADDR(paddr), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
        .PRDATA(prdata), .regs_expected(regs_exp), .data_out(dout), .operation_done(done),
        .num_of_errors(noe), .gm_data_out(gm), .gm_num_of_errors(gnoe), .clr_stats(clr),
        .busy(busy), .pass_count(pass_c), .fail_count(fail_c), .timeout_count(to_c),
        .err_flags(flags), .last_latency(last_l), .hist0(h0), .hist1(h1), .hist2(h2),
        .max_latency_seen(maxl));

    enc_dec_scoreboard #(.MAX_LATENCY(MAXL), .CNT_WIDTH(2)) u_sat (
        .clk(clk), .rst(rst), .PADDR(paddr), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
        .PRDATA(prdata), .regs_expected(regs_exp), .data_out(dout), .operation_done(done),
        .num_of_errors(noe), .gm_data_out(gm), .gm_num_of_errors(gnoe), .clr_stats(clr),
        .busy(s_busy), .pass_count(s_pass), .fail_count(s_fail), .timeout_count(s_to),
        .err_flags(s_flags), .last_latency(s_last), .hist0(s_h0), .hist1(s_h1), .hist2(s_h2),
        .max_latency_seen(s_maxl));

    typedef struct {
        int          delay;
        logic [31:0] d;
        logic [31:0] g;
        logic [1:0]  n;
        logic [1:0]  gn;
        int          e_pass;
        int          e_fail;
        int          e_to;
        logic [5:0]  e_flags;
        int          e_last;
        int          e_h0;
        int          e_h1;
        int          e_h2;
        int          e_max;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic apb_access(input logic [19:0] a, input logic wr);
        paddr = a; pwrite = wr; psel = 1'b1; penable = 1'b0;
        tick();
        penable = 1'b1;
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic drive_done(input logic [31:0] d, input logic [31:0] g, input logic [1:0] n, input logic [1:0] gn);
        dout = d; gm = g; noe = n; gnoe = gn; done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    // delay 0 means no done: the op is left to time out
    task automatic do_op(input int delay, input logic [31:0] d, input logic [31:0] g, input logic [1:0] n, input logic [1:0] gn);
        apb_access(20'h00000, 1'b1);
        if (delay == 0) begin
            repeat (MAXL) tick();
        end else begin
            repeat (delay - 1) tick();
            drive_done(d, g, n, gn);
        end
    endtask

    initial begin
        vecs[0] = '{3, 32'hCAFE0001, 32'hCAFE0001, 2'd0, 2'd0, 1, 0, 0, 6'b000000, 3, 1, 0, 0, 3};
        vecs[1] = '{2, 32'h00001234, 32'h00001235, 2'd1, 2'd1, 0, 1, 0, 6'b000001, 2, 0, 0, 0, 2};
        vecs[2] = '{2, 32'h00001234, 32'h00001235, 2'd2, 2'd2, 1, 0, 0, 6'b000000, 2, 0, 0, 1, 2};
        vecs[3] = '{1, 32'h0000BEEF, 32'h0000BEEF, 2'd1, 2'd2, 0, 1, 0, 6'b000010, 1, 0, 0, 0, 1};
        vecs[4] = '{2, 32'h00000055, 32'h00000055, 2'd3, 2'd3, 0, 1, 0, 6'b000100, 2, 0, 0, 0, 2};
        vecs[5] = '{3, 32'h00000055, 32'h00000056, 2'd3, 2'd3, 0, 1, 0, 6'b000101, 3, 0, 0, 0, 3};
        vecs[6] = '{8, 32'h12345678, 32'h12345678, 2'd0, 2'd0, 1, 0, 0, 6'b000000, 8, 1, 0, 0, 8};
        vecs[7] = '{0, 32'h0, 32'h0, 2'd0, 2'd0, 0, 1, 1, 6'b001000, 0, 0, 0, 0, 0};

        // Reset with inputs toggling
        for (int i = 0; i < 4; i++) begin
            psel = i[0]; penable = i[0]; pwrite = 1'b1; done = ~i[0]; prdata = 32'(i);
            tick();
        end
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; done = 1'b0; prdata = 32'd0;
        check("rst_busy", busy, 0);
        check("rst_pass", pass_c, 0);
        check("rst_fail", fail_c, 0);
        check("rst_to", to_c, 0);
        check("rst_flags", flags, 0);
        check("rst_last", last_l, 0);
        check("rst_hist", {h0, h1, h2, maxl}, 0);
        rst = 1'b0;
        tick();

        // Basic op, busy high for exactly 3 cycles
        apb_access(20'h00000, 1'b1);
        check("b_busy0", busy, 1);
        tick();
        check("b_busy1", busy, 1);
        tick();
        check("b_busy2", busy, 1);
        drive_done(32'h1, 32'h1, 2'd0, 2'd0);
        check("b_busy3", busy, 0);
        check("b_pass", pass_c, 1);
        check("b_last", last_l, 3);

        // Table-driven single ops
        for (int v = 0; v < 8; v++) begin
            clr_pulse();
            do_op(vecs[v].delay, vecs[v].d, vecs[v].g, vecs[v].n, vecs[v].gn);
            check($sformatf("v%0d_pass", v), pass_c, vecs[v].e_pass);
            check($sformatf("v%0d_fail", v), fail_c, vecs[v].e_fail);
            check($sformatf("v%0d_to", v), to_c, vecs[v].e_to);
            check($sformatf("v%0d_flags", v), flags, vecs[v].e_flags);
            check($sformatf("v%0d_last", v), last_l, vecs[v].e_last);
            check($sformatf("v%0d_busy", v), busy, 0);
            check($sformatf("v%0d_h0", v), h0, HIST ? vecs[v].e_h0 : 0);
            check($sformatf("v%0d_h1", v), h1, HIST ? vecs[v].e_h1 : 0);
            check($sformatf("v%0d_h2", v), h2, HIST ? vecs[v].e_h2 : 0);
            check($sformatf("v%0d_max", v), maxl, HIST ? vecs[v].e_max : 0);
        end

        // Spurious done after timeout
        drive_done(32'h0, 32'h0, 2'd0, 2'd0);
        check("sp_flags", flags, 6'b101000);
        check("sp_fail", fail_c, 1);
        check("sp_to", to_c, 1);

        // Timeout boundary: still busy one cycle before the limit
        clr_pulse();
        apb_access(20'h00000, 1'b1);
        repeat (MAXL - 1) tick();
        check("tob_busy", busy, 1);
        check("tob_to", to_c, 0);
        tick();
        check("toa_busy", busy, 0);
        check("toa_to", to_c, 1);

        // Register read mismatch and match
        clr_pulse();
        prdata = 32'hA; regs_exp = 32'hB;
        apb_access(20'h00010, 1'b0);
        check("rd_flags", flags, 6'b010000);
        check("rd_cnt", {pass_c, fail_c, to_c}, 0);
        clr_pulse();
        prdata = 32'hB;
        apb_access(20'h00010, 1'b0);
        check("rdok_flags", flags, 0);

        // Write to a non-zero low address does not start
        apb_access(20'h00004, 1'b1);
        check("nostart_busy", busy, 0);

        // Overlapping start abandons the pending op
        clr_pulse();
        apb_access(20'h00000, 1'b1);
        apb_access(20'h10000, 1'b1);
        check("ov_flags", flags, 6'b100000);
        check("ov_fail", fail_c, 1);
        check("ov_busy", busy, 1);
        tick();
        drive_done(32'h7, 32'h7, 2'd1, 2'd1);
        check("ov_pass", pass_c, 1);
        check("ov_last", last_l, 2);

        // Done and start on the same edge
        clr_pulse();
        apb_access(20'h00000, 1'b1);
        paddr = 20'h00000; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
        tick();
        penable = 1'b1;
        drive_done(32'h9, 32'h9, 2'd0, 2'd0);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        check("ds_pass", pass_c, 1);
        check("ds_flags", flags, 0);
        check("ds_busy", busy, 1);
        check("ds_last", last_l, 2);
        drive_done(32'h9, 32'h9, 2'd0, 2'd0);
        check("ds_pass2", pass_c, 2);
        check("ds_last2", last_l, 1);
        check("ds_busy2", busy, 0);

        // Saturation on the narrow instance, then clear
        clr_pulse();
        for (int k = 0; k < 5; k++) do_op(1, 32'h3, 32'h3, 2'd0, 2'd0);
        check("sat_main", pass_c, 5);
        check("sat_narrow", s_pass, 3);
        clr_pulse();
        check("clr_main", {pass_c, fail_c, to_c, last_l}, 0);
        check("clr_narrow", {s_pass, s_fail, s_to, s_last, s_flags}, 0);
        check("clr_hist", {h0, h1, h2, maxl}, 0);

        // Histogram error mix 2x0, 1x1, 1x2
        do_op(1, 32'h1, 32'h1, 2'd0, 2'd0);
        do_op(2, 32'h2, 32'h2, 2'd0, 2'd0);
        do_op(1, 32'h3, 32'h3, 2'd1, 2'd1);
        do_op(4, 32'h4, 32'h5, 2'd2, 2'd2);
        check("mix_pass", pass_c, 4);
        check("mix_h0", h0, HIST ? 2 : 0);
        check("mix_h1", h1, HIST ? 1 : 0);
        check("mix_h2", h2, HIST ? 1 : 0);
        check("mix_max", maxl, HIST ? 4 : 0);

        // Clear wins over a simultaneous event
        clr = 1'b1;
        drive_done(32'h0, 32'h0, 2'd0, 2'd0);
        clr = 1'b0;
        check("clrwin_flags", flags, 0);

        // Reset mid-operation
        apb_access(20'h00000, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        check("mr_busy", busy, 0);
        check("mr_cnt", {pass_c, fail_c, to_c}, 0);
        drive_done(32'h0, 32'h0, 2'd0, 2'd0);
        check("mr_flags", flags, 6'b100000);
        check("mr_cnt2", {pass_c, fail_c, to_c}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/enc_dec_scoreboard.md
# enc_dec_scoreboard

Synthesizable, parametrised scoreboard for the ECC encoder/decoder testbench. It replaces single-shot property checks with a cycle-accurate checking engine. It snoops the APB control bus and the DUT result interface, and times each operation against a configurable latency bound. It compares results to the golden-model outputs and keeps saturating pass/fail/timeout counters and sticky error flags that the bench or a wrapper can read at end of test.

## Interface
Parameters:
- DATA_WIDTH, 32, width of data_out / gm_data_out
- AMBA_ADDR_WIDTH, 20, PADDR width
- AMBA_WORD, 32, PRDATA / regs_expected width
- MAX_LATENCY, 8, maximum cycles from start write to operation_done (≥1)
- CNT_WIDTH, 16, width of every statistics counter

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- PADDR  in  AMBA_ADDR_WIDTH  APB address
- PSEL, PENABLE, PWRITE  in  1 each  APB control
- PRDATA  in  AMBA_WORD  DUT read data
- regs_expected  in  AMBA_WORD  golden register value for the current read
- data_out  in  DATA_WIDTH  DUT result
- operation_done  in  1  DUT completion strobe
- num_of_errors  in  2  DUT error count
- gm_data_out  in  DATA_WIDTH  golden result
- gm_num_of_errors  in  2  golden error count
- clr_stats  in  1  synchronous clear of counters and flags
- busy  out  1  high in WAIT_DONE
- pass_count, fail_count, timeout_count  out  CNT_WIDTH each
- err_flags  out  6  sticky: [0] data mismatch, [1] error-count mismatch, [2] num_of_errors==3, [3] timeout, [4] register read mismatch, [5] protocol (overlap/spurious done)
- last_latency  out  CNT_WIDTH  latency of last completed operation
- hist0, hist1, hist2  out  CNT_WIDTH each  passing-check counts per num_of_errors value (see Configuration)
- max_latency_seen  out  CNT_WIDTH  (see Configuration)

## Operation
- Start event: PSEL & PENABLE & PWRITE & (PADDR[3:0]==0), sampled at clk edge.
- FSM states: IDLE, WAIT_DONE.
  - IDLE + start → WAIT_DONE, latency counter lat=0.
  - WAIT_DONE, each edge: lat increments. If operation_done, run the check and go to IDLE. Else if lat reaches MAX_LATENCY, record a timeout and go to IDLE.
- Check at done:
  - data_ok = (num_of_errors==2) or (data_out==gm_data_out).
  - cnt_ok = (num_of_errors==gm_num_of_errors).
  - illegal = (num_of_errors==3).
  - Pass if data_ok & cnt_ok & !illegal: pass_count+1.
  - Otherwise fail_count+1 and set flags [0]/[1]/[2] per failing term.
- last_latency := lat+1 at done (the done edge counts as 1).
- Timeout: timeout_count+1, fail_count+1, set flag[3].
- Read check, in any state: PSEL & PENABLE & !PWRITE & (PRDATA != regs_expected) sets flag[4]. No counter change.
- Boundary cases:
  - start while in WAIT_DONE without done: flag[5], fail_count+1 for the abandoned op, timer restarts (lat=0), stay in WAIT_DONE.
  - done and start on the same edge in WAIT_DONE: check the pending op normally, then re-enter WAIT_DONE with lat=0. No flag[5].
  - done in IDLE: flag[5], no counter change.
  - done on the same edge lat reaches MAX_LATENCY: done wins, no timeout.
  - All counters saturate at all-ones.
  - clr_stats zeroes counters, flags, last_latency and histograms. FSM state is unaffected. If an event occurs on the same edge, clr_stats wins.
- Reset mid-operation: the pending op is dropped, nothing is counted, the FSM goes to IDLE.

## Timing
- Reset values: busy=0, all counters 0, err_flags=0, last_latency=0, hist*=0, max_latency_seen=0. FSM is in IDLE.
- All outputs are registered. Counter and flag updates are visible one cycle after the sampling edge.
- busy rises the cycle after the start edge and falls the cycle after the done or timeout edge.
- Maximum detectable latency is MAX_LATENCY. The timeout is reported on the edge where lat==MAX_LATENCY.

## Configuration
- Macro ENC_DEC_SCOREBOARD_HIST_EN.
  - Defined: on each passing check, hist0, hist1 or hist2 (indexed by num_of_errors) increments, saturating. max_latency_seen tracks the maximum last_latency value.
  - Undefined: the histogram and max-tracking logic is not compiled. hist0/1/2 and max_latency_seen are driven constant 0, and the ports remain for a stable interface.

## Test plan
- Reset with inputs toggling → all outputs 0; start at PADDR=0x0 followed by done 3 cycles later with matching golden data → pass_count=1, last_latency=3, busy high for 3 cycles.
- Start, done after 2 cycles with data_out=0x1234, gm_data_out=0x1235, num_of_errors=1 → fail_count=1, err_flags=6'b000001. Repeat with num_of_errors=2 and the same data mismatch → pass.
- Start, no done for MAX_LATENCY=8 cycles → timeout_count=1, fail_count=1, err_flags[3]=1, busy=0. A done arriving afterwards → err_flags[5]=1.
- Done with num_of_errors=3, gm=3 → fail, err_flags[2]=1. APB read with PRDATA=0xA, regs_expected=0xB → err_flags[4]=1, counters unchanged.
- Set CNT_WIDTH=2 and run 5 passing ops → pass_count=3 (saturated). Assert clr_stats → all counters 0. With HIST_EN: hist counts match the injected error mix, e.g. 2×0, 1×1, 1×2 → hist0=2, hist1=1, hist2=1.
- Assert rst 2 cycles after a start → FSM returns to IDLE, counters stay 0. A later done raises flag[5] only.
